poly_tone_sequencer: RTL and testbench
======================================

Name: poly_tone_sequencer

Overview:
Multi-voice successor to the single-voice tone generator. A shared tempo strobe advances a step counter. Each step, every voice loads a half-period divider from its own external note-ROM port and produces a square wave whose amplitude follows a linear-decay envelope. The voices are summed, and the sum drives a single 1-bit audio output, which is PWM by default and sigma-delta when the optional feature is enabled. It sits between the note ROMs and the chip output pin.

Parameters:
NUM_VOICES, 2, number of voices (1..8)
BW, 24, divider / tempo counter width
ENV_W, 8, envelope amplitude width
STEP_W, 6, step index width
DECAY_DIV, 4096, clock cycles per envelope decrement (>=1)
Derived, not overridable: VW = max(1, clog2(NUM_VOICES)); MW = ENV_W+VW.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
en_i  in  1  run enable; 0 = pause + mute
tempo_max_i  in  BW  strobe period minus 1
seq_len_i  in  STEP_W  last step index before wrap
divider_i  in  NUM_VOICES*BW  per-voice half-period from ROMs, voice v = bits [v*BW +: BW]; 0 = rest
step_o  out  STEP_W  current step, drives all ROM addresses
step_strb_o  out  1  one-cycle tempo strobe
mix_o  out  MW  registered voice sum
pwm_o  out  1  audio bit

Behaviour:
- Clocking and reset (decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: all counters 0, step_o 0, step_strb_o 0, mix_o 0, pwm_o 0. Per voice: div_q 0, env 0, sq 0. load_pend is set to 1.
- Asserting rst_i at any point mid-operation gives exactly these values on the next edge.
- Tempo:
  - With en_i=1, tcnt increments. When tcnt==tempo_max_i, tcnt goes to 0 and step_strb_o=1 for that cycle.
  - tempo_max_i=0 gives a strobe every enabled cycle.
  - With en_i=0, tcnt holds and no strobe is produced.
- Step:
  - On a strobe, step_o <= (step_o >= seq_len_i) ? 0 : step_o+1.
  - The >= comparison covers seq_len_i being lowered below the current step: the next strobe wraps to 0.
- Load event: L = en_i & (load_pend | strb_d), where strb_d is step_strb_o delayed one cycle, so the ROM sees the updated step_o.
  - L clears load_pend.
  - Step 0 is therefore loaded on the first enabled cycle after reset.
- On L, for each voice:
  - div_q <= divider_i slice; ph <= 0; sq <= (slice!=0).
  - env <= (slice!=0) ? 2^ENV_W-1 : 0.
- Latency: strobe at cycle T, step_o new at T+1, load at edge ending T+1, new note visible on sq/env at T+2.
- Tone, per voice, while en_i=1:
  - If div_q==0: sq and ph held at 0.
  - Otherwise ph counts 0..div_q-1; at div_q-1, ph <= 0 and sq toggles. Half period = div_q cycles; div_q=1 toggles every cycle.
- Decay:
  - A shared prescaler counts 0..DECAY_DIV-1 while en_i=1 and ticks on wrap.
  - A tick decrements every nonzero env by 1, saturating at 0.
  - If L and a tick occur in the same cycle, L wins.
- Mixer: amp_v = sq_v ? env_v : 0. mix_o <= en_i ? sum(amp_v) : 0, with 1-cycle latency and no overflow, since the sum is at most NUM_VOICES*(2^ENV_W-1) < 2^MW.
- en_i=0: tempo, step, tone and decay all freeze, and mix_o goes to 0 the next cycle. Deasserting and reasserting resumes the same step, phase and envelope.
- PWM (default):
  - pcnt is an MW-bit free-running counter that runs regardless of en_i.
  - duty_q <= mix_o when pcnt is all ones.
  - pwm_o <= (pcnt < duty_q), registered. Period = 2^MW cycles.
  - duty_q=0 gives constant 0.

Optional Feature:
TONE_SIGMA_DELTA_EN
- Defined: the PWM path is replaced by a first-order sigma-delta modulator.
  - acc is MW+1 bits; acc <= {1'b0, acc[MW-1:0]} + mix_o; pwm_o <= acc[MW] (registered carry).
  - acc resets to 0.
  - Output density is mix_o/2^MW.
- Undefined: PWM as above, with no acc register present.

Test Plan:
- Run with tempo_max_i=4, then assert rst_i for 3 cycles mid-note -> step_o=0, mix_o=0, pwm_o=0, step_strb_o=0; step 0 reloaded on the first cycle after release.
- tempo_max_i=9, seq_len_i=3, en_i=1 -> step_strb_o pulses every 10 cycles; step_o runs 0,1,2,3,0,1. Then set seq_len_i=1 while step_o=3 -> next step_o is 0.
- NUM_VOICES=2, DECAY_DIV=4096, divider voice0=5, voice1=0 -> voice0 sq toggles every 5 cycles; mix_o alternates 0/255 in 5-cycle runs; voice1 contributes 0.
- DECAY_DIV=4, voice0 divider=2 -> env falls by 1 every 4 cycles to 0 and stays there; next load restores 255. A load coinciding with a tick gives 255.
- Both dividers=3, sq phases aligned, env max -> mix_o=510; default build gives pwm_o high 510 of 512 cycles. With TONE_SIGMA_DELTA_EN, pwm_o density is 510/512 over 512 cycles.
- Drop en_i for 20 cycles mid-note -> step_o, ph and env frozen; mix_o=0 one cycle later; on reassertion the same phase and step resume with no extra strobe.

Source files
------------

// File: rtl/poly_tone_sequencer.sv
// Multi-voice step sequencer: per-voice square-wave tones with linear-decay envelopes, summed to a 1-bit output.
// Output stage is PWM by default; define TONE_SIGMA_DELTA_EN to use a first-order sigma-delta modulator instead.
module poly_tone_sequencer #(
    parameter int NUM_VOICES = 2,
    parameter int BW         = 24,
    parameter int ENV_W      = 8,
    parameter int STEP_W     = 6,
    parameter int DECAY_DIV  = 4096,
    localparam int VW        = ($clog2(NUM_VOICES) > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int MW        = ENV_W + VW
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [BW-1:0]            tempo_max_i,
    input  logic [STEP_W-1:0]        seq_len_i,
    input  logic [NUM_VOICES*BW-1:0] divider_i,
    output logic [STEP_W-1:0]        step_o,
    output logic                     step_strb_o,
    output logic [MW-1:0]            mix_o,
    output logic                     pwm_o
);

    localparam int PW = ($clog2(DECAY_DIV) > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_DIV - 1);

    logic [BW-1:0]     tcnt_reg;
    logic              step_strb_reg;
    logic              strb_d_reg;
    logic              load_pend_reg;
    logic [STEP_W-1:0] step_reg;
    logic [PW-1:0]     pre_reg;
    logic [MW-1:0]     mix_reg;
    logic              pwm_reg;

    logic              load;
    logic              tick;
    logic [ENV_W-1:0]  amp [NUM_VOICES];
    logic [MW-1:0]     sum_next;

    // Loading one cycle after the strobe lets the ROMs see the new step address.
    assign load = en_i & (load_pend_reg | strb_d_reg);
    assign tick = en_i & (pre_reg == PRE_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_reg      <= '0;
            step_strb_reg <= 1'b0;
            strb_d_reg    <= 1'b0;
            load_pend_reg <= 1'b1;
            step_reg      <= '0;
            pre_reg       <= '0;
        end else begin
            strb_d_reg    <= step_strb_reg;
            step_strb_reg <= 1'b0;
            if (en_i) begin
                if (tcnt_reg == tempo_max_i) begin
                    tcnt_reg      <= '0;
                    step_strb_reg <= 1'b1;
                end else begin
                    tcnt_reg <= tcnt_reg + 1'b1;
                end
                pre_reg <= tick ? '0 : pre_reg + 1'b1;
            end
            // >= so that shrinking seq_len below the current step wraps on the next strobe
            if (step_strb_reg) begin
                step_reg <= (step_reg >= seq_len_i) ? '0 : step_reg + 1'b1;
            end
            if (load) begin
                load_pend_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [BW-1:0]    slice;
            logic [BW-1:0]    div_reg;
            logic [BW-1:0]    ph_reg;
            logic             sq_reg;
            logic [ENV_W-1:0] env_reg;

            assign slice = divider_i[gi*BW +: BW];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    div_reg <= '0;
                    ph_reg  <= '0;
                    sq_reg  <= 1'b0;
                    env_reg <= '0;
                end else if (load) begin
                    // A load overrides a coincident decay tick.
                    div_reg <= slice;
                    ph_reg  <= '0;
                    sq_reg  <= (slice != '0);
                    env_reg <= (slice != '0) ? '1 : '0;
                end else if (en_i) begin
                    if (div_reg == '0) begin
                        ph_reg <= '0;
                        sq_reg <= 1'b0;
                    end else if (ph_reg == div_reg - 1'b1) begin
                        ph_reg <= '0;
                        sq_reg <= ~sq_reg;
                    end else begin
                        ph_reg <= ph_reg + 1'b1;
                    end
                    if (tick && (env_reg != '0)) begin
                        env_reg <= env_reg - 1'b1;
                    end
                end
            end

            assign amp[gi] = sq_reg ? env_reg : '0;
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum_next = sum_next + MW'(amp[v]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mix_reg <= '0;
        end else begin
            mix_reg <= en_i ? sum_next : '0;
        end
    end

`ifdef TONE_SIGMA_DELTA_EN
    logic [MW:0] acc_reg;

    // Carry out of the accumulator is the 1-bit density-modulated output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_reg <= '0;
            pwm_reg <= 1'b0;
        end else begin
            acc_reg <= {1'b0, acc_reg[MW-1:0]} + {1'b0, mix_reg};
            pwm_reg <= acc_reg[MW];
        end
    end
`else
    logic [MW-1:0] pcnt_reg;
    logic [MW-1:0] duty_reg;

    // Duty is only updated at the period boundary so each PWM frame is glitch-free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_reg <= '0;
            duty_reg <= '0;
            pwm_reg  <= 1'b0;
        end else begin
            pcnt_reg <= pcnt_reg + 1'b1;
            if (&pcnt_reg) begin
                duty_reg <= mix_reg;
            end
            pwm_reg <= (pcnt_reg < duty_reg);
        end
    end
`endif

    assign step_o      = step_reg;
    assign step_strb_o = step_strb_reg;
    assign mix_o       = mix_reg;
    assign pwm_o       = pwm_reg;

endmodule

// File: tb/tb_poly_tone_sequencer.sv
// Scoreboard bench for poly_tone_sequencer: two instances (slow and fast decay) share all stimulus.
module tb_poly_tone_sequencer;

    localparam int NV     = 2;
    localparam int BW     = 24;
    localparam int ENV_W  = 8;
    localparam int STEP_W = 6;
    localparam int MW     = 9;
    localparam int EMAX   = 255;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [BW-1:0]       tmax;
    logic [STEP_W-1:0]   seq_len;
    logic [NV*BW-1:0]    div;

    logic [STEP_W-1:0]   step0, step1;
    logic                strb0, strb1;
    logic [MW-1:0]       mix0, mix1;
    logic                pwm0, pwm1;

    always #5 clk = ~clk;

    poly_tone_sequencer #(.NUM_VOICES(NV), .BW(BW), .ENV_W(ENV_W), .STEP_W(STEP_W), .DECAY_DIV(4096)) u_dut_slow (
        .clk_i(clk), .rst_i(rst), .en_i(en), .tempo_max_i(tmax), .seq_len_i(seq_len),
        .divider_i(div), .step_o(step0), .step_strb_o(strb0), .mix_o(mix0), .pwm_o(pwm0)
    );

    poly_tone_sequencer #(.NUM_VOICES(NV), .BW(BW), .ENV_W(ENV_W), .STEP_W(STEP_W), .DECAY_DIV(4)) u_dut_fast (
        .clk_i(clk), .rst_i(rst), .en_i(en), .tempo_max_i(tmax), .seq_len_i(seq_len),
        .divider_i(div), .step_o(step1), .step_strb_o(strb1), .mix_o(mix1), .pwm_o(pwm1)
    );

    typedef struct {
        int step;
        int strb;
        int mix0;
        int mix1;
        int pwm0;
        int pwm1;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference state, index k = instance (0 slow decay, 1 fast decay)
    int m_tcnt, m_step;
    bit m_strb, m_strbd, m_pend;
    int m_div [2][NV];
    int m_ph  [2][NV];
    int m_env [2][NV];
    bit m_sq  [2][NV];
    int m_pre [2];
    int m_mix [2];
    int m_pcnt[2];
    int m_duty[2];
    int m_acc [2];
    bit m_pwm [2];

    // stepping-sequence tracking
    bit track = 0;
    bit step_due = 0;
    int cyc = 0;
    int last_strb = 0;
    int n_strb = 0;
    int exp_steps[$];

    function automatic int dd(input int k);
        return (k == 0) ? 4096 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit   l;
        bit   tk;
        int   sum;
        int   sl;
        exp_t e;
        if (rst) begin
            m_tcnt = 0; m_step = 0; m_strb = 0; m_strbd = 0; m_pend = 1;
            for (int k = 0; k < 2; k++) begin
                m_pre[k] = 0; m_mix[k] = 0; m_pcnt[k] = 0; m_duty[k] = 0; m_acc[k] = 0; m_pwm[k] = 0;
                for (int v = 0; v < NV; v++) begin
                    m_div[k][v] = 0; m_ph[k][v] = 0; m_env[k][v] = 0; m_sq[k][v] = 0;
                end
            end
        end else begin
            l = en && (m_pend || m_strbd);
            for (int k = 0; k < 2; k++) begin
`ifdef TONE_SIGMA_DELTA_EN
                m_pwm[k] = (m_acc[k] >= (1 << MW));
                m_acc[k] = (m_acc[k] % (1 << MW)) + m_mix[k];
`else
                m_pwm[k] = (m_pcnt[k] < m_duty[k]);
                if (m_pcnt[k] == (1 << MW) - 1) m_duty[k] = m_mix[k];
                m_pcnt[k] = (m_pcnt[k] + 1) % (1 << MW);
`endif
                sum = 0;
                for (int v = 0; v < NV; v++) if (m_sq[k][v]) sum += m_env[k][v];
                m_mix[k] = en ? sum : 0;
                tk = en && (m_pre[k] == dd(k) - 1);
                if (en) m_pre[k] = tk ? 0 : m_pre[k] + 1;
                for (int v = 0; v < NV; v++) begin
                    sl = int'(div[v*BW +: BW]);
                    if (l) begin
                        m_div[k][v] = sl;
                        m_ph[k][v]  = 0;
                        m_sq[k][v]  = (sl != 0);
                        m_env[k][v] = (sl != 0) ? EMAX : 0;
                    end else if (en) begin
                        if (m_div[k][v] == 0) begin
                            m_sq[k][v] = 0; m_ph[k][v] = 0;
                        end else if (m_ph[k][v] == m_div[k][v] - 1) begin
                            m_ph[k][v] = 0; m_sq[k][v] = !m_sq[k][v];
                        end else begin
                            m_ph[k][v]++;
                        end
                        if (tk && m_env[k][v] > 0) m_env[k][v]--;
                    end
                end
            end
            if (m_strb) m_step = (m_step >= int'(seq_len)) ? 0 : m_step + 1;
            m_strbd = m_strb;
            if (en && m_tcnt == int'(tmax)) begin
                m_tcnt = 0; m_strb = 1;
            end else begin
                m_strb = 0;
                if (en) m_tcnt++;
            end
            if (l) m_pend = 0;
        end
        e.step = m_step; e.strb = m_strb;
        e.mix0 = m_mix[0]; e.mix1 = m_mix[1];
        e.pwm0 = m_pwm[0]; e.pwm1 = m_pwm[1];
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            chk("step_slow", 32'(step0), e.step);
            chk("step_fast", 32'(step1), e.step);
            chk("strb_slow", 32'(strb0), e.strb);
            chk("strb_fast", 32'(strb1), e.strb);
            chk("mix_slow",  32'(mix0),  e.mix0);
            chk("mix_fast",  32'(mix1),  e.mix1);
            chk("pwm_slow",  32'(pwm0),  e.pwm0);
            chk("pwm_fast",  32'(pwm1),  e.pwm1);
            if (track) begin
                if (step_due) begin
                    chk("step_seq", 32'(step0), exp_steps.pop_front());
                    step_due = 0;
                end
                if (strb0 === 1'b1) begin
                    chk("strb_period", cyc - last_strb, 10);
                    last_strb = cyc;
                    n_strb++;
                    step_due = (exp_steps.size() > 0);
                end
            end
        end
    endtask

    task automatic set_div(input int d0, input int d1);
        div[0*BW +: BW] = BW'(d0);
        div[1*BW +: BW] = BW'(d1);
    endtask

    initial begin
        rst = 1; en = 0; tmax = 4; seq_len = 3; div = '0;
        set_div(5, 0);
        run(3);
        rst = 0; en = 1;
        run(40);
        // reset mid-note, then step 0 reload on release
        rst = 1;
        run(3);
        rst = 0;
        run(20);

        // strobe spacing and step wrap, including seq_len lowered below current step
        rst = 1; tmax = 9; seq_len = 3;
        run(3);
        rst = 0; en = 1;
        exp_steps = '{1, 2, 3, 0, 1};
        cyc = 0; last_strb = 0; n_strb = 0; track = 1;
        run(35);
        seq_len = 1;
        run(20);
        track = 0;
        chk("strb_count", n_strb, 5);

        // two equal-pitch voices, PWM frames, then pause/resume mid-note
        rst = 1; tmax = 1023; seq_len = 3;
        set_div(3, 3);
        run(2);
        rst = 0;
        run(1100);
        en = 0;
        run(20);
        en = 1;
        run(100);

        // fast-decay instance runs envelope to zero, then strobe reloads it
        rst = 1; tmax = 1499;
        set_div(2, 0);
        run(2);
        rst = 0;
        run(1700);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
